// File: rtl/iter_shift_unit.sv
// Multi-cycle shift engine: applies LSL/LSR/ASR by 0..2**AMT_W-1 bits, one bit per clock,
// behind valid/ready handshakes. Also returns the last bit shifted out as a carry flag.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// SHIFT | one 1-bit shift per edge, count down to terminal count of 1
// DONE  | result and carry presented; held until out_ready
module iter_shift_unit #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_shift,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_LSL  = 2'b01;
   localparam logic [1:0] OP_LSR  = 2'b10;
   localparam logic [1:0] OP_ASR  = 2'b11;

   state_t           state_q;
   logic [WIDTH-1:0] work_q;
   logic [1:0]       op_q;
   logic [AMT_W-1:0] count_q;
   logic             carry_q;

   logic [WIDTH-1:0] sh_data;
   logic             sh_carry;
   logic             accept;

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state_q == IDLE) && reset_n;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

   // One-bit shift primitive applied to the working register.
   always_comb begin
      sh_data  = work_q;
      sh_carry = 1'b0;
      case (op_q)
         OP_LSL: begin
            sh_data  = {work_q[WIDTH-2:0], 1'b0};
            sh_carry = work_q[WIDTH-1];
         end
         OP_LSR: begin
            sh_data  = {1'b0, work_q[WIDTH-1:1]};
            sh_carry = work_q[0];
         end
         OP_ASR: begin
            sh_data  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            sh_carry = work_q[0];
         end
         default: begin
            sh_data  = work_q;
            sh_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         work_q    <= '0;
         op_q      <= OP_NONE;
         count_q   <= '0;
         carry_q   <= 1'b0;
         out_data  <= '0;
         out_carry <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  work_q  <= in_data;
                  op_q    <= in_shift;
                  count_q <= in_amt;
                  carry_q <= 1'b0;
                  if ((in_amt == '0) || (in_shift == OP_NONE)) begin
                     out_data  <= in_data;
                     out_carry <= 1'b0;
                     state_q   <= DONE;
                  end else begin
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_q  <= sh_data;
               carry_q <= sh_carry;
               count_q <= count_q - 1'b1;
               // SHIFT is only entered with a nonzero count, so the terminal
               // compare at 1 stops the counter before it can wrap.
               if (count_q == AMT_W'(1)) begin
                  out_data  <= sh_data;
                  out_carry <= sh_carry;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: hand-computed vectors for each op, latency,
// busy duration, backpressure and reset in the middle of an operation.
module tb_iter_shift_unit;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_shift;
   logic [3:0]  in_amt;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_carry;
   logic        busy;

   int checks = 0;
   int errors = 0;

   iter_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request with out_ready=1 and check latency, busy length,
   // single-cycle out_valid and the result/carry held afterwards in IDLE.
   task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] amt, input logic [15:0] exp_d, input logic exp_c,
                         input int exp_lat);
      int lat;
      int busy_cyc;
      int ov_cyc;
      bit seen;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_shift  = op;
      in_amt    = amt;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'hA5A5;
      in_shift = 2'b01;
      in_amt   = 4'd7;
      lat = 0; busy_cyc = 0; ov_cyc = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         busy_cyc++;
         if (out_valid) begin
            ov_cyc++;
            if (!seen) begin
               seen = 1'b1;
               lat  = i;
               check({tag, "_data"},  32'(out_data),  32'(exp_d));
               check({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
            end
         end
         @(posedge clk);
         #1;
      end
      check({tag, "_seen_valid"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat + 1));
      check({tag, "_valid_cycles"}, 32'(ov_cyc), 32'd1);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_hold_data"}, 32'(out_data), 32'(exp_d));
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shift  = '0;
      in_amt    = '0;
      out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_carry", 32'(out_carry), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      run_op("lsl3",     16'h8421, 2'b01, 4'd3,  16'h2108, 1'b0, 3);
      run_op("asr4",     16'h80F8, 2'b11, 4'd4,  16'hF80F, 1'b1, 4);
      run_op("asr15",    16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 15);
      run_op("lsr15",    16'hFFFF, 2'b10, 4'd15, 16'h0001, 1'b1, 15);
      run_op("amt0",     16'h1234, 2'b01, 4'd0,  16'h1234, 1'b0, 0);
      run_op("opnone",   16'h1234, 2'b00, 4'd9,  16'h1234, 1'b0, 0);
      run_op("lsl1",     16'h8000, 2'b01, 4'd1,  16'h0000, 1'b1, 1);

      // Backpressure: result must hold while new requests are ignored.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0001;
      in_shift  = 2'b01;
      in_amt    = 4'd2;
      @(posedge clk);
      #1;
      in_data  = 16'hBEEF;
      in_shift = 2'b10;
      in_amt   = 4'd1;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", 32'(out_data), 32'h0004);
         check("bp_out_carry", 32'(out_carry), 32'd0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      check("bp_release_data", 32'(out_data), 32'h0004);

      // Reset after four shifts of a ten-bit LSR.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hF000;
      in_shift = 2'b10;
      in_amt   = 4'd10;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_busy", 32'(busy), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_carry", 32'(out_carry), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      check("mid_no_stale_valid", 32'(out_valid), 32'd0);

      run_op("after_rst_lsr4", 16'h0010, 2'b10, 4'd4, 16'h0001, 1'b0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
